indicador_ring_multi: RTL and testbench

- Parametrised successor of the single-channel alarm indicator.
- Compares NUM_ALARMAS BCD alarm times against the RTC time.
- Runs a per-channel ring state machine with a timed ring duration and a stop input.
- Outputs registered BCD time-remaining digits (24 h wrap) for one selected channel; sits between the RTC reader and the display/buzzer logic.

---
 rtl/indicador_ring_multi_if.sv | 48 ++++
 rtl/indicador_ring_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_indicador_ring_multi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/indicador_ring_multi_if.sv
// indicador_ring_multi_if
// Bundles every non-clock/reset signal of indicador_ring_multi.
//   master modport : drives alarm settings, RTC time, tick/stop pulses and
//                    the channel select; reads the ring flags and digits.
//   slave modport  : the indicator itself (inputs/outputs mirrored).
//   Signals: alarma_on, alarma_hms, HRTC/MRTC/SRTC, tick_seg, apagar, sel,
//            activring, ring_canal, hora1/hora2/min1/min2/seg1/seg2.
//   Optional macro INDICADOR_RING_SNOOZE_EN adds the posponer pulse.
interface indicador_ring_multi_if #(
  parameter int NUM_ALARMAS = 2,
  parameter int SEL_W       = 1
);
  logic [NUM_ALARMAS-1:0]    alarma_on;
  logic [24*NUM_ALARMAS-1:0] alarma_hms;
  logic [7:0]                HRTC;
  logic [7:0]                MRTC;
  logic [7:0]                SRTC;
  logic                      tick_seg;
  logic                      apagar;
  logic [SEL_W-1:0]          sel;
`ifdef INDICADOR_RING_SNOOZE_EN
  logic                      posponer;
`endif
  logic                      activring;
  logic [NUM_ALARMAS-1:0]    ring_canal;
  logic [3:0]                hora1;
  logic [3:0]                hora2;
  logic [3:0]                min1;
  logic [3:0]                min2;
  logic [3:0]                seg1;
  logic [3:0]                seg2;

  modport master (
`ifdef INDICADOR_RING_SNOOZE_EN
    output posponer,
`endif
    output alarma_on, alarma_hms, HRTC, MRTC, SRTC, tick_seg, apagar, sel,
    input  activring, ring_canal, hora1, hora2, min1, min2, seg1, seg2
  );

  modport slave (
`ifdef INDICADOR_RING_SNOOZE_EN
    input  posponer,
`endif
    input  alarma_on, alarma_hms, HRTC, MRTC, SRTC, tick_seg, apagar, sel,
    output activring, ring_canal, hora1, hora2, min1, min2, seg1, seg2
  );
endinterface

// File: rtl/indicador_ring_multi.sv
// indicador_ring_multi
// Multi-channel alarm indicator. Each of NUM_ALARMAS BCD alarm times is
// compared against the RTC time; a rising match starts that channel ringing
// for RING_SEG tick_seg pulses unless stopped by apagar. For the channel
// picked by sel, the time remaining until the alarm ((alarm - RTC) mod 24 h)
// is shown as registered BCD digits.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : indicador_ring_multi_if.slave (alarms, RTC, pulses, sel,
//                activring, ring_canal, remaining-time digits)
// Optional feature macro: INDICADOR_RING_SNOOZE_EN adds the posponer input
// and a SNOOZE state lasting 60*SNOOZE_MIN tick_seg pulses.
module indicador_ring_multi #(
  parameter int NUM_ALARMAS = 2,
  parameter int SEL_W       = 1,
  parameter int RING_SEG    = 30,
  parameter int SNOOZE_MIN  = 5
) (
  input logic                   clk,
  input logic                   reset,
  indicador_ring_multi_if.slave bus
);

`ifdef INDICADOR_RING_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_e;
  localparam logic [15:0] SNOOZE_LAST = 16'(60 * SNOOZE_MIN - 1);
`else
  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_e;
`endif

  // Value the ring counter holds just before the tick that ends the ring.
  localparam logic [7:0] RING_LAST = 8'(RING_SEG - 1);

  state_e                 state_q   [NUM_ALARMAS];
  state_e                 state_d   [NUM_ALARMAS];
  logic [7:0]             ringCnt_q [NUM_ALARMAS];
  logic [7:0]             ringCnt_d [NUM_ALARMAS];
`ifdef INDICADOR_RING_SNOOZE_EN
  logic [15:0]            snoozeCnt_q [NUM_ALARMAS];
  logic [15:0]            snoozeCnt_d [NUM_ALARMAS];
`endif
  logic [NUM_ALARMAS-1:0] match;
  logic [NUM_ALARMAS-1:0] matchEdge;
  logic [NUM_ALARMAS-1:0] match_prev_q;
  logic [NUM_ALARMAS-1:0] ringNext;
  logic [NUM_ALARMAS-1:0] ring_canal_q;
  logic                   activring_q;

  // Exact equality only, so invalid BCD cannot corrupt the FSMs.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_ALARMAS; k++) begin
      match[k] = (bus.alarma_hms[24*k +: 24] == {bus.HRTC, bus.MRTC, bus.SRTC});
    end
  end

  assign matchEdge = match & ~match_prev_q;

  // Per-channel next state; alarma_on low overrides everything, apagar
  // beats a coincident match edge or snooze request.
  always_comb begin
    ringNext = '0;
    for (int k = 0; k < NUM_ALARMAS; k++) begin
      state_d[k]   = state_q[k];
      ringCnt_d[k] = ringCnt_q[k];
`ifdef INDICADOR_RING_SNOOZE_EN
      snoozeCnt_d[k] = snoozeCnt_q[k];
`endif
      if (!bus.alarma_on[k]) begin
        state_d[k] = IDLE;
      end else begin
        case (state_q[k])
          IDLE: state_d[k] = ARMED;
          ARMED: begin
            if (matchEdge[k] && !bus.apagar) begin
              state_d[k]   = RINGING;
              ringCnt_d[k] = '0;
            end
          end
          RINGING: begin
            if (bus.apagar) begin
              state_d[k] = ARMED;
`ifdef INDICADOR_RING_SNOOZE_EN
            end else if (bus.posponer) begin
              state_d[k]     = SNOOZE;
              snoozeCnt_d[k] = '0;
`endif
            end else if (bus.tick_seg) begin
              ringCnt_d[k] = ringCnt_q[k] + 8'd1;
              if (ringCnt_q[k] == RING_LAST) begin
                state_d[k] = ARMED;
              end
            end
          end
`ifdef INDICADOR_RING_SNOOZE_EN
          SNOOZE: begin
            if (bus.apagar) begin
              state_d[k] = ARMED;
            end else if (bus.tick_seg) begin
              snoozeCnt_d[k] = snoozeCnt_q[k] + 16'd1;
              if (snoozeCnt_q[k] == SNOOZE_LAST) begin
                state_d[k]   = RINGING;
                ringCnt_d[k] = '0;
              end
            end
          end
`endif
          default: state_d[k] = IDLE;
        endcase
      end
      ringNext[k] = (state_d[k] == RINGING);
    end
  end

  // Ring flags are registered from the next state so they track state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_ALARMAS; k++) begin
        state_q[k]   <= IDLE;
        ringCnt_q[k] <= '0;
`ifdef INDICADOR_RING_SNOOZE_EN
        snoozeCnt_q[k] <= '0;
`endif
      end
      match_prev_q <= '0;
      ring_canal_q <= '0;
      activring_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_ALARMAS; k++) begin
        state_q[k]   <= state_d[k];
        ringCnt_q[k] <= ringCnt_d[k];
`ifdef INDICADOR_RING_SNOOZE_EN
        snoozeCnt_q[k] <= snoozeCnt_d[k];
`endif
      end
      match_prev_q <= match;
      ring_canal_q <= ringNext;
      activring_q  <= |ringNext;
    end
  end

  assign bus.ring_canal = ring_canal_q;
  assign bus.activring  = activring_q;

  // Returns {borrow_out, digit} of a - b - bin in a digit of the given base.
  function automatic logic [4:0] digSub(input logic [3:0] a, input logic [3:0] b,
                                        input logic bin, input logic [3:0] base);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, base} - {1'b0, b} - {4'b0, bin};
    if (t >= {1'b0, base}) return {1'b0, 4'(t - {1'b0, base})};
    else return {1'b1, t[3:0]};
  endfunction

  logic [23:0] selHms;
  logic        selValid;
  logic [4:0]  s2R, s1R, m2R, m1R;
  logic [7:0]  hA, hR, hD;
  logic [3:0]  hTens, hUnits;

  // Out-of-range sel leaves selValid low, which blanks the digits.
  always_comb begin
    selHms   = '0;
    selValid = 1'b0;
    for (int k = 0; k < NUM_ALARMAS; k++) begin
      if (int'(bus.sel) == k) begin
        selHms   = bus.alarma_hms[24*k +: 24];
        selValid = 1'b1;
      end
    end
  end

  // Seconds and minutes subtract digit-wise; hours go through binary so the
  // mod-24 wrap is a single compare.
  always_comb begin
    s2R = digSub(selHms[3:0],   bus.SRTC[3:0], 1'b0,   4'd10);
    s1R = digSub(selHms[7:4],   bus.SRTC[7:4], s2R[4], 4'd6);
    m2R = digSub(selHms[11:8],  bus.MRTC[3:0], s1R[4], 4'd10);
    m1R = digSub(selHms[15:12], bus.MRTC[7:4], m2R[4], 4'd6);
    hA  = 8'(selHms[23:20]) * 8'd10 + 8'(selHms[19:16]);
    hR  = 8'(bus.HRTC[7:4]) * 8'd10 + 8'(bus.HRTC[3:0]);
    hD  = hA + 8'd24 - hR - {7'b0, m1R[4]};
    if (hD >= 8'd24) hD = hD - 8'd24;
    if (hD >= 8'd20) begin
      hTens  = 4'd2;
      hUnits = 4'(hD - 8'd20);
    end else if (hD >= 8'd10) begin
      hTens  = 4'd1;
      hUnits = 4'(hD - 8'd10);
    end else begin
      hTens  = 4'd0;
      hUnits = hD[3:0];
    end
  end

  logic [3:0] hora1_q, hora2_q, min1_q, min2_q, seg1_q, seg2_q;

  always_ff @(posedge clk) begin
    if (reset || !selValid) begin
      hora1_q <= '0;
      hora2_q <= '0;
      min1_q  <= '0;
      min2_q  <= '0;
      seg1_q  <= '0;
      seg2_q  <= '0;
    end else begin
      hora1_q <= hTens;
      hora2_q <= hUnits;
      min1_q  <= m1R[3:0];
      min2_q  <= m2R[3:0];
      seg1_q  <= s1R[3:0];
      seg2_q  <= s2R[3:0];
    end
  end

  assign bus.hora1 = hora1_q;
  assign bus.hora2 = hora2_q;
  assign bus.min1  = min1_q;
  assign bus.min2  = min2_q;
  assign bus.seg1  = seg1_q;
  assign bus.seg2  = seg2_q;

endmodule

// File: tb/tb_indicador_ring_multi.sv
// tb_indicador_ring_multi
// Directed bench for indicador_ring_multi with NUM_ALARMAS=2, SEL_W=2,
// RING_SEG=3, SNOOZE_MIN=1. Snooze steps are present only when
// INDICADOR_RING_SNOOZE_EN is defined.
module tb_indicador_ring_multi;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  indicador_ring_multi_if #(.NUM_ALARMAS(2), .SEL_W(2)) bus ();

  indicador_ring_multi #(
    .NUM_ALARMAS(2),
    .SEL_W(2),
    .RING_SEG(3),
    .SNOOZE_MIN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.HRTC = h;
    bus.MRTC = m;
    bus.SRTC = s;
    tick();
  endtask

  task automatic pulseTick();
    bus.tick_seg = 1'b1;
    tick();
    bus.tick_seg = 1'b0;
  endtask

  task automatic pulseApagar();
    bus.apagar = 1'b1;
    tick();
    bus.apagar = 1'b0;
  endtask

  function automatic logic [31:0] digits();
    return 32'({bus.hora1, bus.hora2, bus.min1, bus.min2, bus.seg1, bus.seg2});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset          = 1'b1;
    bus.alarma_on  = 2'b00;
    bus.alarma_hms = '0;
    bus.HRTC       = 8'h00;
    bus.MRTC       = 8'h00;
    bus.SRTC       = 8'h00;
    bus.tick_seg   = 1'b0;
    bus.apagar     = 1'b0;
    bus.sel        = 2'd0;
`ifdef INDICADOR_RING_SNOOZE_EN
    bus.posponer   = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_ring", 32'(bus.ring_canal), 32'h0);
    checkOutput("reset_act", 32'(bus.activring), 32'h0);
    checkOutput("reset_digits", digits(), 32'h0);

    // Ch0 armed at 07:30:00, two seconds away
    reset          = 1'b0;
    bus.alarma_hms = {24'h000000, 24'h073000};
    bus.alarma_on  = 2'b01;
    applyStimulus(8'h07, 8'h29, 8'h58);
    checkOutput("remain_2s", digits(), 32'h000002);
    checkOutput("armed_no_ring", 32'(bus.ring_canal), 32'h0);
    applyStimulus(8'h07, 8'h30, 8'h00);
    checkOutput("match_ring", 32'(bus.ring_canal), 32'h1);
    checkOutput("match_act", 32'(bus.activring), 32'h1);
    checkOutput("match_digits", digits(), 32'h000000);
    pulseApagar();
    checkOutput("apagar_stop", 32'(bus.ring_canal), 32'h0);
    tick();
    tick();
    checkOutput("held_no_retrigger", 32'(bus.ring_canal), 32'h0);

    // Ring times out on the third tick_seg
    applyStimulus(8'h07, 8'h29, 8'h59);
    applyStimulus(8'h07, 8'h30, 8'h00);
    checkOutput("timeout_start", 32'(bus.ring_canal), 32'h1);
    pulseTick();
    checkOutput("timeout_tick1", 32'(bus.ring_canal), 32'h1);
    tick();
    pulseTick();
    checkOutput("timeout_tick2", 32'(bus.ring_canal), 32'h1);
    pulseTick();
    checkOutput("timeout_tick3", 32'(bus.ring_canal), 32'h0);
    checkOutput("timeout_act", 32'(bus.activring), 32'h0);
    applyStimulus(8'h07, 8'h29, 8'h59);
    applyStimulus(8'h07, 8'h30, 8'h00);
    checkOutput("rearmed_after_timeout", 32'(bus.ring_canal), 32'h1);
    pulseApagar();

    // Both channels at 12:00:00, apagar coincident with the match edge
    bus.alarma_hms = {24'h120000, 24'h120000};
    bus.alarma_on  = 2'b11;
    bus.sel        = 2'd1;
    applyStimulus(8'h11, 8'h59, 8'h59);
    tick();
    bus.apagar = 1'b1;
    applyStimulus(8'h12, 8'h00, 8'h00);
    bus.apagar = 1'b0;
    checkOutput("apagar_wins", 32'(bus.ring_canal), 32'h0);
    tick();
    checkOutput("apagar_wins_held", 32'(bus.ring_canal), 32'h0);
    applyStimulus(8'h11, 8'h59, 8'h59);
    applyStimulus(8'h12, 8'h00, 8'h00);
    checkOutput("both_ring", 32'(bus.ring_canal), 32'h3);
    checkOutput("both_act", 32'(bus.activring), 32'h1);

    // Reset held two clocks while ringing
    applyStimulus(8'h11, 8'h00, 8'h00);
    checkOutput("ring_through_rtc_change", 32'(bus.ring_canal), 32'h3);
    checkOutput("remain_1h", digits(), 32'h010000);
    reset = 1'b1;
    tick();
    checkOutput("midreset_ring", 32'(bus.ring_canal), 32'h0);
    checkOutput("midreset_act", 32'(bus.activring), 32'h0);
    checkOutput("midreset_digits", digits(), 32'h0);
    tick();
    reset = 1'b0;

    // Disarming one channel drops only that channel
    applyStimulus(8'h11, 8'h59, 8'h59);
    applyStimulus(8'h12, 8'h00, 8'h00);
    checkOutput("post_reset_ring", 32'(bus.ring_canal), 32'h3);
    bus.alarma_on = 2'b10;
    tick();
    checkOutput("disarm_ch0", 32'(bus.ring_canal), 32'h2);
    pulseApagar();
    checkOutput("apagar_ch1", 32'(bus.ring_canal), 32'h0);

    // Remaining-time wrap and select range
    bus.alarma_hms = {24'h000005, 24'h073000};
    bus.sel        = 2'd1;
    applyStimulus(8'h23, 8'h59, 8'h59);
    checkOutput("wrap_6s", digits(), 32'h000006);
    bus.sel = 2'd2;
    tick();
    checkOutput("sel2_zero", digits(), 32'h0);
    bus.sel = 2'd3;
    tick();
    checkOutput("sel3_zero", digits(), 32'h0);
    bus.sel = 2'd0;
    tick();
    checkOutput("wrap_ch0", digits(), 32'h073001);
    bus.alarma_hms = {24'h120000, 24'h073000};
    bus.sel        = 2'd1;
    applyStimulus(8'h13, 8'h45, 8'h30);
    checkOutput("borrow_chain", digits(), 32'h221430);

`ifdef INDICADOR_RING_SNOOZE_EN
    // Snooze: 60 tick_seg off, then ringing again; apagar in snooze ends it
    bus.alarma_hms = {24'h120000, 24'h073000};
    bus.alarma_on  = 2'b01;
    applyStimulus(8'h07, 8'h29, 8'h59);
    applyStimulus(8'h07, 8'h30, 8'h00);
    checkOutput("snooze_start_ring", 32'(bus.ring_canal), 32'h1);
    bus.posponer = 1'b1;
    tick();
    bus.posponer = 1'b0;
    checkOutput("snooze_off", 32'(bus.ring_canal), 32'h0);
    for (int i = 0; i < 59; i++) pulseTick();
    checkOutput("snooze_59", 32'(bus.ring_canal), 32'h0);
    pulseTick();
    checkOutput("snooze_60_ring", 32'(bus.ring_canal), 32'h1);
    bus.posponer = 1'b1;
    tick();
    bus.posponer = 1'b0;
    pulseApagar();
    for (int i = 0; i < 60; i++) pulseTick();
    checkOutput("snooze_apagar_stays_off", 32'(bus.ring_canal), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
